// File: rtl/serial_addsub.sv
// Bit-serial add/subtract unit: one full-adder cell handles one bit per clock, LSB first.
// Flags and result are registered only on entry to the done state and hold until the next result.
module serial_addsub #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             Sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C0,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] F,
    output logic             C4,
    output logic             OF,
    output logic             ZF
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-2:0] r_sr_q, r_sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             sub_q, sub_d;
    logic             c_msb_q, c_msb_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic             c4_q, c4_d;
    logic             of_q, of_d;
    logic             zf_q, zf_d;

    logic             s_bit;
    logic             c_new;
    logic [WIDTH-1:0] r_next;
    logic             last_bit;

    assign s_bit    = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
    assign c_new    = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & c_q) | (b_sr_q[0] & c_q);
    assign r_next   = {s_bit, r_sr_q};
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StShift;
            StShift: if (last_bit) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q == StShift);
        done = (state_q == StDone);
    end

    // Subtraction runs as A + ~B + ~C0; the latched mode turns the final carry into a borrow.
    always_comb begin
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        r_sr_d  = r_sr_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        sub_d   = sub_q;
        c_msb_d = c_msb_q;
        f_d     = f_q;
        c4_d    = c4_q;
        of_d    = of_q;
        zf_d    = zf_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_sr_d = A;
                    b_sr_d = Sub ? ~B : B;
                    c_d    = Sub ? ~C0 : C0;
                    cnt_d  = '0;
                    sub_d  = Sub;
                end
            end
            StShift: begin
                r_sr_d = r_next[WIDTH-1:1];
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                c_d    = c_new;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 2)) c_msb_d = c_new;
                if (last_bit) begin
                    f_d  = r_next;
                    c4_d = c_new ^ sub_q;
                    of_d = c_msb_q ^ c_new;
                    zf_d = (r_next == '0);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            r_sr_q  <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            sub_q   <= 1'b0;
            c_msb_q <= 1'b0;
            f_q     <= '0;
            c4_q    <= 1'b0;
            of_q    <= 1'b0;
            zf_q    <= 1'b0;
        end else begin
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            r_sr_q  <= r_sr_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            sub_q   <= sub_d;
            c_msb_q <= c_msb_d;
            f_q     <= f_d;
            c4_q    <= c4_d;
            of_q    <= of_d;
            zf_q    <= zf_d;
        end
    end

    assign F  = f_q;
    assign C4 = c4_q;
    assign OF = of_q;
    assign ZF = zf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: directed and random operations against an arithmetic
// reference model, plus protocol cases (ignored start, mid-operation reset, held start).
module tb_serial_addsub;

    localparam int W  = 4;
    localparam int CB = 3;

    logic         clk   = 1'b0;
    logic         rst   = 1'b0;
    logic         start = 1'b0;
    logic         Sub   = 1'b0;
    logic         C0    = 1'b0;
    logic [W-1:0] A     = '0;
    logic [W-1:0] B     = '0;
    logic         busy, done, C4, OF, ZF;
    logic [W-1:0] F;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [W-1:0] f;
        logic         c4;
        logic         of;
        logic         zf;
    } res_t;

    res_t last_exp = '0;

    serial_addsub #(.WIDTH(W), .CW(CB)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .Sub   (Sub),
        .A     (A),
        .B     (B),
        .C0    (C0),
        .busy  (busy),
        .done  (done),
        .F     (F),
        .C4    (C4),
        .OF    (OF),
        .ZF    (ZF)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Plain integer arithmetic: unsigned result/carry, signed range test for overflow.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c0, input logic sub);
        res_t e;
        int ua = int'(a);
        int ub = int'(b);
        int ci = int'(c0);
        int sa = a[W-1] ? ua - (1 << W) : ua;
        int sb = b[W-1] ? ub - (1 << W) : ub;
        int r, sr;
        if (!sub) begin
            r    = ua + ub + ci;
            sr   = sa + sb + ci;
            e.c4 = (r >= (1 << W));
        end else begin
            r    = ua - ub - ci;
            sr   = sa - sb - ci;
            e.c4 = (ua < ub + ci);
        end
        e.f  = W'(r & ((1 << W) - 1));
        e.of = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
        e.zf = (e.f == '0);
        return e;
    endfunction

    task automatic check_result(input res_t e);
        check("F", 32'(F), 32'(e.f));
        check("C4", 32'(C4), 32'(e.c4));
        check("OF", 32'(OF), 32'(e.of));
        check("ZF", 32'(ZF), 32'(e.zf));
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c0,
                          input logic sub, input bit scramble);
        res_t e = model(a, b, c0, sub);
        int   n;
        int   busy_cycles = 0;
        bit   seen = 1'b0;
        @(negedge clk);
        A = a; B = b; C0 = c0; Sub = sub; start = 1'b1;
        @(posedge clk);
        for (n = 1; n <= W + 3; n++) begin
            @(negedge clk);
            if (scramble && n <= W) begin
                start = 1'($urandom);
                A     = W'($urandom);
                B     = W'($urandom);
                C0    = 1'($urandom);
                Sub   = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
            check("F_steady_in_shift", 32'(F), 32'(last_exp.f));
            if (busy) busy_cycles++;
        end
        check("done_seen", 32'(seen), 32'd1);
        check("latency", 32'(n), 32'(W + 1));
        check("busy_len", 32'(busy_cycles), 32'(W));
        check("busy_in_done", 32'(busy), 32'd0);
        check_result(e);
        last_exp = e;
        @(negedge clk);
        start = 1'b0;
        check("done_one_cycle", 32'(done), 32'd0);
        check("F_hold", 32'(F), 32'(e.f));
    endtask

    initial begin
        int   pulses[$];
        res_t e;
        bit   any_done;

        // Reset asserted while clk is low must clear outputs without an edge.
        #2 rst = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_F", 32'(F), 32'd0);
        check("rst_flags", 32'({C4, OF, ZF}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_F", 32'(F), 32'd0);

        run_op(4'b1100, 4'b1011, 1'b0, 1'b0, 1'b0);
        run_op(4'b1011, 4'b0010, 1'b1, 1'b1, 1'b0);
        run_op(4'b0011, 4'b0100, 1'b0, 1'b1, 1'b0);
        run_op(4'b0111, 4'b1000, 1'b1, 1'b0, 1'b0);
        run_op(4'b0111, 4'b0001, 1'b0, 1'b0, 1'b0);
        run_op(4'b1001, 4'b0110, 1'b1, 1'b1, 1'b1);

        for (int i = 0; i < 30; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), bit'($urandom));
        end

        // Reset with a non-zero result held must clear it immediately.
        run_op(4'b0101, 4'b0001, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("rst_clears_F", 32'(F), 32'd0);
        check("rst_clears_C4", 32'(C4), 32'd0);
        last_exp = '0;
        @(negedge clk);
        rst = 1'b0;

        // Reset on the second shift cycle abandons the operation.
        run_op(4'b0110, 4'b0011, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        A = 4'b1111; B = 4'b0001; C0 = 1'b0; Sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("shift_busy_before_rst", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_F", 32'(F), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        any_done = 1'b0;
        repeat (W + 3) begin
            @(negedge clk);
            if (done) any_done = 1'b1;
        end
        check("midrst_no_done", 32'(any_done), 32'd0);
        check("midrst_F_after", 32'(F), 32'd0);
        last_exp = '0;

        // Start held high: a new operation on every idle cycle.
        e = model(4'b0110, 4'b0111, 1'b1, 1'b0);
        @(negedge clk);
        A = 4'b0110; B = 4'b0111; C0 = 1'b1; Sub = 1'b0; start = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                pulses.push_back(i);
                check_result(e);
            end
        end
        start = 1'b0;
        check("held_pulse_count", 32'(pulses.size()), 32'd3);
        for (int k = 1; k < pulses.size(); k++) begin
            check("held_interval", 32'(pulses[k] - pulses[k-1]), 32'(W + 2));
        end
        repeat (W + 3) @(negedge clk);
        check("held_idle_after", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Bit-serial, multi-cycle add/subtract unit, the sequential counterpart of the lab's combinational 4-bit ripple adder.
- Accepts two WIDTH-bit operands and a carry/borrow-in on a start pulse.
- Processes one bit per clock, LSB first, through a single full-adder cell.
- Reports sum or difference plus carry/borrow, signed overflow and zero flags with a done pulse.
- Used as the arithmetic slave of the lab's sequential datapath exercises.

Parameters:
- WIDTH, 4, operand and result width in bits (≥2).
- CW, 3, bit-counter width; must satisfy 2^CW ≥ WIDTH.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  reset.
- start  input  1  request; sampled only in IDLE.
- Sub  input  1  mode: 0 add, 1 subtract; latched with operands.
- A  input  WIDTH  operand A (unsigned/two's complement); latched on accepted start.
- B  input  WIDTH  operand B; latched on accepted start.
- C0  input  1  carry-in (add) or borrow-in (subtract); latched on accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; result outputs updated this cycle.
- F  output  WIDTH  result.
- C4  output  1  add: carry-out; subtract: borrow-out.
- OF  output  1  signed two's-complement overflow.
- ZF  output  1  F == 0.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is asynchronous and active-high. While rst=1, all state and outputs are cleared immediately, independent of clk.
- Reset values: state=IDLE, busy=0, done=0, F=0, C4=0, OF=0, ZF=0. Internal operand, shift and counter registers are all 0.
- States: IDLE, SHIFT, DONE.
- IDLE → SHIFT:
  - On the edge where start=1.
  - Latch A into shift register a_sr.
  - Latch B, or ~B if Sub=1, into b_sr.
  - Load carry c = C0 if Sub=0, else ~C0.
  - Clear bit counter; remember Sub. busy=1 from the following cycle.
- SHIFT operation:
  - Each edge computes s = a_sr[0]^b_sr[0]^c and the new c = majority(a_sr[0], b_sr[0], c).
  - Shift s into the result shift register from the MSB side; shift a_sr and b_sr right.
  - Increment the counter.
  - On the edge processing bit WIDTH-2, also capture that carry-out as c_msb_in (the carry into the MSB).
- SHIFT → DONE:
  - On the edge processing bit WIDTH-1 (WIDTH edges after entry).
  - The same edge registers F = final shift result and C4 = c_final XOR Sub_latched.
  - Also registers OF = c_msb_in XOR c_final and ZF = (F==0).
  - done=1 and busy=0 in the DONE cycle.
- DONE → IDLE: unconditional on the next edge; done returns to 0.
- Latency: start sampled at edge 0 → done high in the cycle after edge WIDTH; WIDTH+1 cycles start-to-done. Minimum issue interval is WIDTH+2 cycles.
- Result persistence: F, C4, OF, ZF update only on entry to DONE. They hold until the next completed operation or reset, and do not glitch during SHIFT.
- start while busy or in DONE: ignored, no queuing. A, B, C0 and Sub may change freely after acceptance.
- Arithmetic (mod 2^WIDTH):
  - Sub=0: F = A+B+C0.
  - Sub=1: F = A−B−C0, with C4=1 iff A < B+C0 (unsigned).
- Reset asserted mid-SHIFT: operation abandoned. Outputs return to reset values, including the previous result, and no done is produced.
- start held high continuously: a new operation begins on each IDLE cycle, i.e. every WIDTH+2 cycles.

Test Plan:
- Reset: assert rst mid-clock-low → all outputs 0 immediately. Release, 3 idle cycles → busy=0, done=0, F=0000.
- Add with carry and overflow: A=1100, B=1011, C0=0, Sub=0, pulse start → done exactly 5 cycles after the start edge with F=0111, C4=1, OF=1, ZF=0. busy is high for exactly 4 cycles.
- Subtract with borrow-in: A=1011, B=0010, C0=1, Sub=1 → F=1000, C4=0, OF=0, ZF=0.
- Negative result: A=0011, B=0100, C0=0, Sub=1 → F=1111, C4=1 (borrow), OF=0, ZF=0.
- Zero and overflow:
  - A=0111, B=1000, C0=1, Sub=0 → F=0000, C4=1, OF=0, ZF=1.
  - Then A=0111, B=0001, C0=0 → F=1000, C4=0, OF=1.
- Protocol edge cases:
  - Toggle start and change A/B during SHIFT → ignored; the original result is produced.
  - Assert rst on the 2nd SHIFT cycle → no done; F=0.
  - Hold start high for 20 cycles → done pulses every 6 cycles.
